// File: rtl/ahb_lite_master_arbiter.sv
// Two-master AHB-Lite arbiter: round-robin with a fairness hold limit, burst-locked
// address-phase ownership, and a data-phase owner that trails by one accepted transfer.
module ahb_lite_master_arbiter #(
   parameter bit          DEFAULT_MASTER = 1'b0,
   parameter int unsigned MAX_HOLD       = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,

   input  logic        M0_HBUSREQ,
   output logic        M0_HGRANT,
   input  logic [31:0] M0_HADDR,
   input  logic [1:0]  M0_HTRANS,
   input  logic        M0_HWRITE,
   input  logic [2:0]  M0_HSIZE,
   input  logic [31:0] M0_HWDATA,

   input  logic        M1_HBUSREQ,
   output logic        M1_HGRANT,
   input  logic [31:0] M1_HADDR,
   input  logic [1:0]  M1_HTRANS,
   input  logic        M1_HWRITE,
   input  logic [2:0]  M1_HSIZE,
   input  logic [31:0] M1_HWDATA,

   output logic        M_HREADY,
   output logic [31:0] M_HRDATA,

   output logic [31:0] S_HADDR,
   output logic [1:0]  S_HTRANS,
   output logic        S_HWRITE,
   output logic [2:0]  S_HSIZE,
   output logic [31:0] S_HWDATA,
   input  logic        S_HREADY,
   input  logic [31:0] S_HRDATA,

   output logic        HMASTER,
   output logic        HMASTER_D
);

   localparam int unsigned       HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   logic              addr_owner_q;
   logic              addr_owner_d;
   logic              data_owner_q;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;

   logic [1:0]        o_trans;
   logic              o_req;
   logic              x_req;

   assign o_trans = addr_owner_q ? M1_HTRANS  : M0_HTRANS;
   assign o_req   = addr_owner_q ? M1_HBUSREQ : M0_HBUSREQ;
   assign x_req   = addr_owner_q ? M0_HBUSREQ : M1_HBUSREQ;

   // Priority order matters: a burst in progress beats both parking and fairness.
   always_comb begin
      addr_owner_d = addr_owner_q;
      if (o_trans == TR_SEQ || o_trans == TR_BUSY) begin
         addr_owner_d = addr_owner_q;
      end else if (!M0_HBUSREQ && !M1_HBUSREQ) begin
         addr_owner_d = DEFAULT_MASTER;
      end else if (x_req && !o_req) begin
         addr_owner_d = ~addr_owner_q;
      end else if (MAX_HOLD > 0 && x_req && o_req && hold_q >= HOLD_LIM) begin
         addr_owner_d = ~addr_owner_q;
      end
   end

   always_comb begin
      hold_d = hold_q;
      if (addr_owner_d != addr_owner_q) begin
         hold_d = '0;
      end else if (MAX_HOLD > 0 && o_trans == TR_NONSEQ && hold_q < HOLD_LIM) begin
         hold_d = hold_q + HOLD_ONE;
      end
   end

   // Wait states freeze everything, so ownership can only move on an accepted transfer.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_owner_q <= DEFAULT_MASTER;
         data_owner_q <= DEFAULT_MASTER;
         hold_q       <= '0;
      end else if (S_HREADY) begin
         addr_owner_q <= addr_owner_d;
         data_owner_q <= addr_owner_q;
         hold_q       <= hold_d;
      end
   end

   assign M0_HGRANT = (addr_owner_d == 1'b0);
   assign M1_HGRANT = (addr_owner_d == 1'b1);

   assign S_HADDR  = addr_owner_q ? M1_HADDR  : M0_HADDR;
   assign S_HTRANS = addr_owner_q ? M1_HTRANS : M0_HTRANS;
   assign S_HWRITE = addr_owner_q ? M1_HWRITE : M0_HWRITE;
   assign S_HSIZE  = addr_owner_q ? M1_HSIZE  : M0_HSIZE;
   assign S_HWDATA = data_owner_q ? M1_HWDATA : M0_HWDATA;

   assign M_HREADY = S_HREADY;
   assign M_HRDATA = S_HRDATA;

   assign HMASTER   = addr_owner_q;
   assign HMASTER_D = data_owner_q;

endmodule
